encoder_responder: RTL and testbench
====================================

ENCODER_RESPONDER -- requirements
Module: encoder_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 40, iClk cycles per UART bit (2.5 Mbit/s at 100 MHz).
REQ-002 SHALL have parameter TURN_CLKS, default 20, cycles oDir is high before the first transmitted start bit.
REQ-003 SHALL have parameter ENC_ID, default 8'h17, encoder ID byte returned for CF 8'h92.
REQ-004 SHALL have port iClk  input  1  sole clock.
REQ-005 SHALL have port iRst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-006 SHALL have port iRx  input  1  request line from the drive, idle high, asynchronous.
REQ-007 SHALL have port oTx  output  1  response line, idle high.
REQ-008 SHALL have port oDir  output  1  transceiver direction, 1 = responder drives bus.
REQ-009 SHALL have port iPosition  input  24  single-turn absolute position.
REQ-010 SHALL have port iStatus  input  8  status field (SF) value.
REQ-011 SHALL have port oBusy  output  1  high from CF acceptance until oDir falls.
REQ-012 SHALL have port oFrame_err  output  1  one-cycle pulse on bad stop bit.
REQ-013 SHALL have port oCmd_err  output  1  one-cycle pulse on unsupported CF.

Function
REQ-014 SHALL double-flop synchronise iRx before any use.
REQ-015 SHALL receive UART 8N1, LSB first; start on falling edge, sampled at CLKS_PER_BIT/2; start not low at mid-bit -> return to IDLE silently.
REQ-016 SHALL sample stop bit at mid-bit; low -> oFrame_err pulse, no response, return to IDLE.
REQ-017 SHALL use states IDLE, RX, DECODE, TURN, TX, RELEASE; RX->DECODE on valid stop sample, DECODE lasts one cycle.
REQ-018 SHALL in DECODE latch iPosition and iStatus; CF 8'h02 -> frame CF,SF,ABS0,ABS1,ABS2,CRC (ABS0 = iPosition[7:0]); CF 8'h92 -> frame CF,SF,ENC_ID,CRC; other -> oCmd_err pulse, IDLE.
REQ-019 SHALL compute CRC as bitwise XOR of all preceding bytes of the frame.
REQ-020 SHALL raise oDir and oBusy on the cycle after DECODE; first start bit begins exactly TURN_CLKS cycles later.
REQ-021 SHALL transmit bytes back-to-back, 8N1, LSB first, no idle gap, each bit exactly CLKS_PER_BIT cycles.
REQ-022 SHALL hold oTx high for one bit time after final stop bit (RELEASE), then drop oDir and oBusy together and return to IDLE.
REQ-023 SHALL ignore iRx while oBusy is high (half duplex); a start edge during TURN/TX/RELEASE is never decoded.
REQ-024 SHALL keep oTx high whenever not inside a start/data bit.

Reset
REQ-025 SHALL on iRst_n low at a clock edge force state IDLE, oTx=1, oDir=0, oBusy=0, oFrame_err=0, oCmd_err=0, all counters 0, including mid-RX or mid-TX.
REQ-026 SHALL after reset release require a fresh falling edge before receiving.

Configuration
REQ-027 SHALL with macro ENC_RESP_ID2_EN defined support CF 8'h92 per REQ-018.
REQ-028 SHALL without ENC_RESP_ID2_EN treat CF 8'h92 as unsupported (oCmd_err pulse, no response) and omit ENC_ID logic.

Structure
REQ-029 SHALL place CF codes (8'h02, 8'h92), frame lengths (6, 4) and state encodings in shared package enc_resp_pkg.
REQ-030 SHALL implement the bit-level receiver as sub-module uart_rx_8n1; framing, turnaround and transmit stay in encoder_responder.

Verification (CLKS_PER_BIT=40, TURN_CLKS=20)
REQ-031 SHALL cover CF 8'h02, iPosition=24'h123456, iStatus=8'h00 -> oDir high 1 cycle after stop sample, bytes 02 00 56 34 12 72 on oTx.
REQ-032 SHALL cover CF 8'h92 with ENC_RESP_ID2_EN, iStatus=8'h00 -> bytes 92 00 17 85; without macro -> oCmd_err pulse, oDir stays 0.
REQ-033 SHALL cover CF 8'h55 -> single oCmd_err pulse, oTx/oDir unchanged.
REQ-034 SHALL cover CF 8'h02 with stop bit low -> oFrame_err pulse, no response; 10-cycle low glitch on idle iRx -> no effect.
REQ-035 SHALL cover iRst_n low during 3rd transmitted byte -> next edge oTx=1, oDir=0, oBusy=0; subsequent CF 8'h02 answered normally.
REQ-036 SHALL cover CF sent while oBusy high -> ignored, current frame completes unaltered.

Source files
------------

// File: rtl/enc_resp_pkg.sv
// -----------------------------------------------------------------------------
// enc_resp_pkg
// Shared constants for the encoder responder: supported command fields (CF),
// response frame lengths, top-level and receiver state encodings, the frame
// container type and the frame CRC helper.
// Optional feature macro (used by encoder_responder): ENC_RESP_ID2_EN.
// -----------------------------------------------------------------------------
package enc_resp_pkg;

    // Command fields
    localparam logic [7:0] CF_POS = 8'h02;   // position request
    localparam logic [7:0] CF_ID2 = 8'h92;   // encoder ID request

    // Response frame lengths in bytes, CRC included
    localparam int LEN_POS = 6;
    localparam int LEN_ID2 = 4;
    localparam int MAX_LEN = 6;

    // Top-level responder states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX      = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_TURN    = 3'd3;
    localparam logic [2:0] ST_TX      = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    // Bit-level receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Byte k of a frame lives in element [k]; element [0] goes out first.
    typedef logic [MAX_LEN-1:0][7:0] frame_t;

    // Places the XOR of bytes 0..len-2 into byte len-1.
    function automatic frame_t sealFrame(input frame_t body, input int len);
        frame_t     f;
        logic [7:0] crc;
        f   = body;
        crc = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < len - 1) crc = crc ^ body[i];
        end
        f[3'(len - 1)] = crc;
        return f;
    endfunction

endpackage

// File: rtl/encoder_responder_if.sv
// -----------------------------------------------------------------------------
// encoder_responder_if
// Bus bundle between a drive (master) and the encoder responder (slave).
//   iRx        request line from the drive, idle high, asynchronous
//   oTx        response line, idle high
//   oDir       transceiver direction, 1 = responder drives the bus
//   iPosition  24-bit single-turn absolute position
//   iStatus    8-bit status field
//   oBusy      high from CF acceptance until oDir falls
//   oFrame_err one-cycle pulse on a bad stop bit
//   oCmd_err   one-cycle pulse on an unsupported CF
// -----------------------------------------------------------------------------
interface encoder_responder_if;
    logic        iRx;
    logic        oTx;
    logic        oDir;
    logic [23:0] iPosition;
    logic [7:0]  iStatus;
    logic        oBusy;
    logic        oFrame_err;
    logic        oCmd_err;

    modport master (
        output iRx, iPosition, iStatus,
        input  oTx, oDir, oBusy, oFrame_err, oCmd_err
    );

    modport slave (
        input  iRx, iPosition, iStatus,
        output oTx, oDir, oBusy, oFrame_err, oCmd_err
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
// Bit-level UART 8N1 receiver, LSB first. The raw line is double-flopped
// before use. A start is recognised only on a falling edge; the start bit is
// re-checked CLKS_PER_BIT/2 cycles later, each following bit one bit time on.
// Ports:
//   iClk, iRst_n  clock, synchronous active-low reset
//   iEn           receiver enable; low holds the receiver idle
//   iRx           raw asynchronous line
//   oByte         received byte (valid with oValid)
//   oActive       a character is being received
//   oValid        strobe on the stop-bit sample when the stop bit is high
//   oFrameErr     strobe on the stop-bit sample when the stop bit is low
// -----------------------------------------------------------------------------
module uart_rx_8n1
    import enc_resp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iRx,
    output logic [7:0] oByte,
    output logic       oActive,
    output logic       oValid,
    output logic       oFrameErr
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic        rxMeta, rxSync, rxPrev;
    logic [1:0]  rxState;
    logic [15:0] cnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic        stopSample;

    assign stopSample = iEn && (rxState == RX_STOP) && (cnt == BIT_LAST);
    assign oValid     = stopSample && rxSync;
    assign oFrameErr  = stopSample && !rxSync;
    assign oActive    = (rxState != RX_IDLE);
    assign oByte      = shiftReg;

    // Sync and edge history reset low: a line already low when reset is
    // released never looks like a falling edge.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rxMeta  <= 1'b0;
            rxSync  <= 1'b0;
            rxPrev  <= 1'b0;
            rxState <= RX_IDLE;
            cnt     <= '0;
            bitIdx  <= '0;
        end else begin
            rxMeta <= iRx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
            if (!iEn) begin
                rxState <= RX_IDLE;
                cnt     <= '0;
                bitIdx  <= '0;
            end else begin
                case (rxState)
                    RX_IDLE: begin
                        if (rxPrev && !rxSync) begin
                            rxState <= RX_START;
                            cnt     <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bitIdx  <= '0;
                            rxState <= rxSync ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            if (bitIdx == 3'd7) rxState <= RX_STOP;
                            else                bitIdx  <= bitIdx + 3'd1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            rxState <= RX_IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Data path: shift register carries no reset.
    always_ff @(posedge iClk) begin
        if (iEn && rxState == RX_DATA && cnt == BIT_LAST)
            shiftReg <= {rxSync, shiftReg[7:1]};
    end

endmodule

// File: rtl/encoder_responder.sv
// -----------------------------------------------------------------------------
// encoder_responder
// Half-duplex absolute-encoder responder. Receives a one-byte command field
// over UART 8N1, then after a turnaround drives back a response frame:
//   CF 8'h02 -> CF, SF, ABS0, ABS1, ABS2, CRC   (ABS0 = iPosition[7:0])
//   CF 8'h92 -> CF, SF, ENC_ID, CRC             (only with ENC_RESP_ID2_EN)
// CRC is the XOR of all preceding frame bytes. The receiver is disabled while
// the responder owns the bus.
// Optional feature macro: ENC_RESP_ID2_EN (enables the CF 8'h92 response).
// Ports:
//   iClk    sole clock
//   iRst_n  synchronous active-low reset
//   bus     encoder_responder_if.slave (iRx, oTx, oDir, iPosition, iStatus,
//           oBusy, oFrame_err, oCmd_err)
// -----------------------------------------------------------------------------
module encoder_responder
    import enc_resp_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 40,
    parameter int         TURN_CLKS    = 20,
    parameter logic [7:0] ENC_ID       = 8'h17
) (
    input  logic               iClk,
    input  logic               iRst_n,
    encoder_responder_if.slave bus
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TURN_LAST = 16'(TURN_CLKS - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [3:0]  bitIdx;      // 0 = start, 1..8 = data, 9 = stop
    logic [2:0]  byteIdx;
    logic [2:0]  lastByte;
    logic        txReg, dirReg, busyReg, frameErrReg, cmdErrReg;

    logic [7:0]  cfReg;
    frame_t      txFrame, posBody, nextFrame;
    logic [7:0]  curByte;

    logic [7:0]  rxByte;
    logic        rxActive, rxValid, rxFrameErr, rxEn;

    assign rxEn = (state == ST_IDLE) || (state == ST_RX);

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iEn       (rxEn),
        .iRx       (bus.iRx),
        .oByte     (rxByte),
        .oActive   (rxActive),
        .oValid    (rxValid),
        .oFrameErr (rxFrameErr)
    );

`ifdef ENC_RESP_ID2_EN
    frame_t idBody;
`endif

    always_comb begin
        posBody      = '0;
        posBody[0]   = cfReg;
        posBody[1]   = bus.iStatus;
        posBody[4:2] = bus.iPosition;
        nextFrame    = sealFrame(posBody, LEN_POS);
`ifdef ENC_RESP_ID2_EN
        idBody    = '0;
        idBody[0] = cfReg;
        idBody[1] = bus.iStatus;
        idBody[2] = ENC_ID;
        if (cfReg == CF_ID2) nextFrame = sealFrame(idBody, LEN_ID2);
`endif
    end

    assign curByte = txFrame[byteIdx];

    // Control path
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bitIdx      <= '0;
            byteIdx     <= '0;
            lastByte    <= '0;
            txReg       <= 1'b1;
            dirReg      <= 1'b0;
            busyReg     <= 1'b0;
            frameErrReg <= 1'b0;
            cmdErrReg   <= 1'b0;
        end else begin
            frameErrReg <= rxFrameErr;
            cmdErrReg   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rxActive) state <= ST_RX;
                end
                ST_RX: begin
                    if (rxValid)        state <= ST_DECODE;
                    else if (!rxActive) state <= ST_IDLE;
                end
                ST_DECODE: begin
                    if (cfReg == CF_POS) begin
                        state    <= ST_TURN;
                        lastByte <= 3'(LEN_POS - 1);
                        dirReg   <= 1'b1;
                        busyReg  <= 1'b1;
                        cnt      <= '0;
                    end
`ifdef ENC_RESP_ID2_EN
                    else if (cfReg == CF_ID2) begin
                        state    <= ST_TURN;
                        lastByte <= 3'(LEN_ID2 - 1);
                        dirReg   <= 1'b1;
                        busyReg  <= 1'b1;
                        cnt      <= '0;
                    end
`endif
                    else begin
                        cmdErrReg <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt     <= '0;
                        bitIdx  <= '0;
                        byteIdx <= '0;
                        txReg   <= 1'b0;
                        state   <= ST_TX;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_TX: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bitIdx == 4'd9) begin
                            if (byteIdx == lastByte) begin
                                state <= ST_RELEASE;
                                txReg <= 1'b1;
                            end else begin
                                byteIdx <= byteIdx + 3'd1;
                                bitIdx  <= '0;
                                txReg   <= 1'b0;
                            end
                        end else begin
                            // Leaving bit bitIdx: next is data bit bitIdx, or stop after bit 8
                            bitIdx <= bitIdx + 4'd1;
                            txReg  <= (bitIdx == 4'd8) ? 1'b1 : curByte[bitIdx[2:0]];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        state   <= ST_IDLE;
                        dirReg  <= 1'b0;
                        busyReg <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path: command byte and response frame are latched, not reset
    always_ff @(posedge iClk) begin
        if (rxValid)             cfReg   <= rxByte;
        if (state == ST_DECODE)  txFrame <= nextFrame;
    end

    assign bus.oTx        = txReg;
    assign bus.oDir       = dirReg;
    assign bus.oBusy      = busyReg;
    assign bus.oFrame_err = frameErrReg;
    assign bus.oCmd_err   = cmdErrReg;

endmodule

// File: tb/tb_encoder_responder.sv
// -----------------------------------------------------------------------------
// tb_encoder_responder
// Directed bench for encoder_responder (CLKS_PER_BIT=40, TURN_CLKS=20).
// Honours ENC_RESP_ID2_EN when the same macro is given to the build.
// -----------------------------------------------------------------------------
module tb_encoder_responder;

    localparam int CLKS = 40;
    localparam int TURN = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encoder_responder_if bus();

    encoder_responder #(
        .CLKS_PER_BIT (CLKS),
        .TURN_CLKS    (TURN),
        .ENC_ID       (8'h17)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    int nChecks   = 0;
    int nFails    = 0;
    int cyc       = 0;
    int startCyc  = 0;
    int nFrameErr = 0;
    int nCmdErr   = 0;

    logic [7:0] expA  [6] = '{8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h72};
    logic [7:0] expB  [6] = '{8'h02, 8'h5A, 8'hEF, 8'hCD, 8'hAB, 8'hD1};
    logic [7:0] expId [6] = '{8'h92, 8'h00, 8'h17, 8'h85, 8'h00, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.oFrame_err) nFrameErr <= nFrameErr + 1;
        if (bus.oCmd_err)   nCmdErr   <= nCmdErr + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(posedge clk) #1 bus.iRx = 1'b0;
        startCyc = cyc;
        repeat (CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 bus.iRx = b[i];
            repeat (CLKS) @(posedge clk);
        end
        #1 bus.iRx = stopBit;
        repeat (CLKS) @(posedge clk);
        #1 bus.iRx = 1'b1;
    endtask

    task automatic noResponse(input int w, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (w) begin
            @(negedge clk);
            if (bus.oDir || !bus.oTx || bus.oBusy) seen = 1'b1;
        end
        checkVal(tag, seen, 0);
    endtask

    task automatic recvFrame(input int n, input logic [7:0] exp [6], input string tag);
        int         t;
        int         lat;
        logic [9:0] bits;
        t = 0;
        while (!bus.oDir && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.oDir) begin
            checkVal({tag, " oDir rise timeout"}, 0, 1);
            return;
        end
        lat = cyc - startCyc;
        checkVal({tag, " oDir after stop"},
                 (lat >= 9*CLKS + CLKS/2 && lat <= 9*CLKS + CLKS/2 + 5), 1);
        checkVal({tag, " oBusy with oDir"}, bus.oBusy, 1);
        t = 0;
        while (bus.oTx && t < TURN + 20) begin
            t++;
            @(negedge clk);
        end
        checkVal({tag, " turnaround"}, t, TURN);
        if (bus.oTx) return;
        repeat (CLKS/2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            for (int m = 0; m < 10; m++) begin
                bits[m] = bus.oTx;
                repeat (CLKS) @(negedge clk);
            end
            checkVal($sformatf("%s byte%0d", tag, k), bits[8:1], exp[k]);
            checkVal($sformatf("%s framing%0d", tag, k), {bits[9], bits[0]}, 2'b10);
        end
        repeat (CLKS/2 - 1) @(negedge clk);
        checkVal({tag, " release hold"}, {bus.oDir, bus.oTx}, 2'b11);
        @(negedge clk);
        checkVal({tag, " bus released"}, {bus.oDir, bus.oBusy, bus.oTx}, 3'b001);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, f0, t;

        // Reset with line held low; a low line at release must not start a receive
        bus.iRx       = 1'b0;
        bus.iPosition = 24'h123456;
        bus.iStatus   = 8'h00;
        rst_n         = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkVal("reset outputs", {bus.oTx, bus.oDir, bus.oBusy, bus.oFrame_err, bus.oCmd_err}, 5'b10000);
        @(posedge clk) #1 rst_n = 1'b1;
        noResponse(500, "low at release");
        bus.iRx = 1'b1;
        noResponse(100, "line rises");
        checkVal("no errs after release", nFrameErr + nCmdErr, 0);

        // Position request
        fork
            sendByte(8'h02, 1'b1);
            recvFrame(6, expA, "pos");
        join
        repeat (20) @(posedge clk);

        // Encoder ID request
        e0 = nCmdErr;
`ifdef ENC_RESP_ID2_EN
        fork
            sendByte(8'h92, 1'b1);
            recvFrame(4, expId, "id2");
        join
        checkVal("id2 no cmd err", nCmdErr - e0, 0);
`else
        sendByte(8'h92, 1'b1);
        noResponse(200, "id2 disabled quiet");
        checkVal("id2 disabled cmd err", nCmdErr - e0, 1);
`endif
        repeat (20) @(posedge clk);

        // Unsupported CF
        e0 = nCmdErr;
        sendByte(8'h55, 1'b1);
        noResponse(200, "cf55 quiet");
        checkVal("cf55 cmd err", nCmdErr - e0, 1);

        // Second position pattern
        bus.iPosition = 24'hABCDEF;
        bus.iStatus   = 8'h5A;
        fork
            sendByte(8'h02, 1'b1);
            recvFrame(6, expB, "pos2");
        join
        bus.iPosition = 24'h123456;
        bus.iStatus   = 8'h00;
        repeat (20) @(posedge clk);

        // Bad stop bit
        f0 = nFrameErr;
        e0 = nCmdErr;
        sendByte(8'h02, 1'b0);
        noResponse(200, "ferr quiet");
        checkVal("ferr pulse", nFrameErr - f0, 1);
        checkVal("ferr no cmd err", nCmdErr - e0, 0);

        // Short low glitch on idle line
        f0 = nFrameErr;
        @(posedge clk) #1 bus.iRx = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.iRx = 1'b1;
        noResponse(500, "glitch quiet");
        checkVal("glitch no errs", (nFrameErr - f0) + (nCmdErr - e0), 0);

        // Request while busy, inputs changed mid-frame
        e0 = nCmdErr;
        fork
            recvFrame(6, expA, "busy");
            begin
                sendByte(8'h02, 1'b1);
                t = 0;
                while (!bus.oDir && t < 1000) begin
                    @(posedge clk);
                    t++;
                end
                repeat (300) @(posedge clk);
                bus.iPosition = 24'hFFFFFF;
                bus.iStatus   = 8'hFF;
                sendByte(8'h55, 1'b1);
            end
        join
        checkVal("busy cf ignored", nCmdErr - e0, 0);
        noResponse(600, "busy no second frame");
        bus.iPosition = 24'h123456;
        bus.iStatus   = 8'h00;

        // Reset during third transmitted byte
        sendByte(8'h02, 1'b1);
        t = 0;
        while (bus.oTx && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2*10*CLKS + CLKS + CLKS/2) @(negedge clk);
        checkVal("byte2 bit0 low", bus.oTx, 0);
        @(posedge clk) #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkVal("mid-tx reset", {bus.oTx, bus.oDir, bus.oBusy}, 3'b100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        fork
            sendByte(8'h02, 1'b1);
            recvFrame(6, expA, "after reset");
        join

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
